// File: rtl/multi_dataflow_tile_sequencer.sv
// Job sequencer for the multi_dataflow HWPE: walks N tiles per start, programming the
// source and sink address generators per tile and raising a single done event per job.
module multi_dataflow_tile_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int TILE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_in_addr_i,
  input  logic [ADDR_W-1:0] cfg_out_addr_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [TILE_W-1:0] cfg_n_tiles_i,
  input  logic [ADDR_W-1:0] cfg_stride_i,
  output logic              src_req_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [LEN_W-1:0]  src_len_o,
  input  logic              src_ack_i,
  input  logic              src_done_i,
  output logic              snk_req_o,
  output logic [ADDR_W-1:0] snk_addr_o,
  output logic [LEN_W-1:0]  snk_len_o,
  input  logic              snk_ack_i,
  input  logic              snk_done_i,
  output logic              engine_clear_o,
  output logic              busy_o,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              done_o
);

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, FIN} state_t;

  localparam logic [TILE_W-1:0] TILE_ONE = {{(TILE_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_addr_q, snk_addr_q, stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [TILE_W-1:0] n_tiles_q, tile_idx_q;
  logic              src_req_q, snk_req_q;
  logic              src_acked_q, snk_acked_q;
  logic              src_done_q, snk_done_q;

  logic src_acked, snk_acked, src_done, snk_done;
  logic cfg_empty, last_tile, tile_done, advance, track_done;

  // A done pulse only counts once its side has accepted the current tile request.
  always_comb begin
    src_acked  = src_acked_q | (src_req_q & src_ack_i);
    snk_acked  = snk_acked_q | (snk_req_q & snk_ack_i);
    src_done   = src_done_q | (src_done_i & src_acked);
    snk_done   = snk_done_q | (snk_done_i & snk_acked);
    cfg_empty  = (cfg_len_i == '0) || (cfg_n_tiles_i == '0);
    last_tile  = (tile_idx_q == (n_tiles_q - TILE_ONE));
    tile_done  = (state_q == WAIT) && src_done && snk_done;
    advance    = tile_done && !last_tile;
    track_done = (state_q == ISSUE) || (state_q == WAIT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = cfg_empty ? FIN : CLR;
      end
      CLR:   state_d = ISSUE;
      ISSUE: begin
        if (src_acked && snk_acked) state_d = WAIT;
      end
      WAIT: begin
        if (tile_done) state_d = last_tile ? FIN : ISSUE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= IDLE;
    else if (clear_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Shadow config, per-tile address walk and per-side handshake tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_addr_q  <= '0;
      snk_addr_q  <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      n_tiles_q   <= '0;
      tile_idx_q  <= '0;
      src_req_q   <= 1'b0;
      snk_req_q   <= 1'b0;
      src_acked_q <= 1'b0;
      snk_acked_q <= 1'b0;
      src_done_q  <= 1'b0;
      snk_done_q  <= 1'b0;
    end else if (clear_i) begin
      src_addr_q  <= '0;
      snk_addr_q  <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      n_tiles_q   <= '0;
      tile_idx_q  <= '0;
      src_req_q   <= 1'b0;
      snk_req_q   <= 1'b0;
      src_acked_q <= 1'b0;
      snk_acked_q <= 1'b0;
      src_done_q  <= 1'b0;
      snk_done_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start_i) begin
        src_addr_q <= cfg_in_addr_i;
        snk_addr_q <= cfg_out_addr_i;
        stride_q   <= cfg_stride_i;
        len_q      <= cfg_len_i;
        n_tiles_q  <= cfg_n_tiles_i;
        tile_idx_q <= '0;
      end else if (advance) begin
        src_addr_q <= src_addr_q + stride_q;
        snk_addr_q <= snk_addr_q + stride_q;
        tile_idx_q <= tile_idx_q + TILE_ONE;
      end

      if ((state_q == CLR) || advance) begin
        src_req_q   <= 1'b1;
        snk_req_q   <= 1'b1;
        src_acked_q <= 1'b0;
        snk_acked_q <= 1'b0;
      end else if (state_q == ISSUE) begin
        src_req_q   <= src_req_q & ~src_ack_i;
        snk_req_q   <= snk_req_q & ~snk_ack_i;
        src_acked_q <= src_acked;
        snk_acked_q <= snk_acked;
      end

      if (track_done && !tile_done) begin
        src_done_q <= src_done;
        snk_done_q <= snk_done;
      end else begin
        src_done_q <= 1'b0;
        snk_done_q <= 1'b0;
      end
    end
  end

  assign src_req_o      = src_req_q;
  assign snk_req_o      = snk_req_q;
  assign src_addr_o     = src_addr_q;
  assign snk_addr_o     = snk_addr_q;
  assign src_len_o      = len_q;
  assign snk_len_o      = len_q;
  assign tile_idx_o     = tile_idx_q;
  assign engine_clear_o = (state_q == CLR);
  assign busy_o         = (state_q == CLR) || (state_q == ISSUE) || (state_q == WAIT);
  assign done_o         = (state_q == FIN);

endmodule
